// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline encodings and widths
//   MEMOP_* : memory access width/extension codes carried by MemOp
//   DM_WORDS_DEFAULT : default data-memory depth in words
//   TNEW_W : width of the Tnew ageing field
package mips_pkg;
  localparam int DM_WORDS_DEFAULT = 1024;
  localparam int TNEW_W = 2;
  typedef enum logic [2:0] {
    MEMOP_W  = 3'b000,
    MEMOP_HU = 3'b001,
    MEMOP_H  = 3'b010,
    MEMOP_BU = 3'b011,
    MEMOP_B  = 3'b100
  } memop_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: E-side inputs and M-side outputs of the memory stage
//   master : upstream/downstream pipeline side (drives E fields, forwardM, ResultW)
//   slave  : mem_stage side (drives the registered M fields and ReadDataM)
interface mem_stage_if;
  import mips_pkg::*;
  logic              RegWriteE, MemWriteE;
  logic [1:0]        MemtoRegE;
  logic [2:0]        MemOpE;
  logic [31:0]       ALUoutE, WriteDataE, PC_4E, ext_immE;
  logic [TNEW_W-1:0] TnewE;
  logic [4:0]        A_rtE, AwriteE;
  logic              forwardM;
  logic [31:0]       ResultW;
  logic              RegWriteM;
  logic [1:0]        MemtoRegM;
  logic [31:0]       PC_4M, ext_immM, ALUoutM, ReadDataM;
  logic [4:0]        A_rtM, AwriteM;
  logic [TNEW_W-1:0] TnewM;
  modport master (
    output RegWriteE, MemWriteE, MemtoRegE, MemOpE, ALUoutE, WriteDataE, PC_4E, ext_immE,
           TnewE, A_rtE, AwriteE, forwardM, ResultW,
    input  RegWriteM, MemtoRegM, PC_4M, ext_immM, ALUoutM, ReadDataM, A_rtM, AwriteM, TnewM
  );
  modport slave (
    input  RegWriteE, MemWriteE, MemtoRegE, MemOpE, ALUoutE, WriteDataE, PC_4E, ext_immE,
           TnewE, A_rtE, AwriteE, forwardM, ResultW,
    output RegWriteM, MemtoRegM, PC_4M, ext_immM, ALUoutM, ReadDataM, A_rtM, AwriteM, TnewM
  );
endinterface

// File: rtl/mem_stage_dm.sv
// dm: data memory with byte/half/word lane merge on store and extended load
//   clk, reset_n : clock, async active-low reset (clears every word)
//   we, op, addr : store enable, MemOp width code, byte address (index wraps)
//   wd           : store data, lane taken from its low bits
//   pc_4         : PC+4 of the M instruction, only used by the store log
//   rd           : combinational extended load data
// Optional DM_DISPLAY_EN prints every committed store.
module dm
  import mips_pkg::*;
#(
  parameter int WORDS = DM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc_4,
  output logic [31:0] rd
);
  localparam int AW = $clog2(WORDS);
  logic [31:0]   mem [WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   cur, mask, merged;
  logic [15:0]   lane;
  logic [4:0]    sh;
  logic          is_h, is_b;
  assign idx  = addr[AW+1:2];
  assign cur  = mem[idx];
  assign is_h = op == MEMOP_H || op == MEMOP_HU;
  assign is_b = op == MEMOP_B || op == MEMOP_BU;
  // one bit-offset drives both the store lane and the load lane; word ignores addr[1:0]
  assign sh     = is_b ? {addr[1:0], 3'b000} : is_h ? {addr[1], 4'b0000} : 5'd0;
  assign mask   = (is_b ? 32'h0000_00ff : is_h ? 32'h0000_ffff : 32'hffff_ffff) << sh;
  assign merged = (cur & ~mask) | ((wd << sh) & mask);
  assign lane   = 16'(cur >> sh);
  assign rd = op == MEMOP_BU ? {24'd0, lane[7:0]} :
              op == MEMOP_B  ? {{24{lane[7]}}, lane[7:0]} :
              op == MEMOP_HU ? {16'd0, lane} :
              op == MEMOP_H  ? {{16{lane[15]}}, lane} : cur;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    else if (we) mem[idx] <= merged;
`ifdef DM_DISPLAY_EN
  always_ff @(posedge clk)
    if (reset_n && we) $display("@%h: *%h <= %h", pc_4 - 32'd4, {addr[31:2], 2'b00}, merged);
`else
  logic unused_bits;
  assign unused_bits = ^{addr[31:AW+2], pc_4};
`endif
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with E/M register, data memory, store forwarding and Tnew ageing
//   clk, reset_n : clock, async active-low reset
//   bus          : mem_stage_if.slave carrying E inputs, forwardM/ResultW and all M outputs
// DM_DISPLAY_EN (see dm) enables a store log; function is unchanged.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
  input logic        clk,
  input logic        reset_n,
  mem_stage_if.slave bus
);
  logic        mem_write_m;
  logic [2:0]  mem_op_m;
  logic [31:0] write_data_m, sd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.RegWriteM <= 1'b0;
      mem_write_m   <= 1'b0;
      bus.MemtoRegM <= '0;
      mem_op_m      <= '0;
      bus.ALUoutM   <= '0;
      write_data_m  <= '0;
      bus.PC_4M     <= '0;
      bus.ext_immM  <= '0;
      bus.A_rtM     <= '0;
      bus.AwriteM   <= '0;
      bus.TnewM     <= '0;
    end else begin
      bus.RegWriteM <= bus.RegWriteE;
      mem_write_m   <= bus.MemWriteE;
      bus.MemtoRegM <= bus.MemtoRegE;
      mem_op_m      <= bus.MemOpE;
      bus.ALUoutM   <= bus.ALUoutE;
      write_data_m  <= bus.WriteDataE;
      bus.PC_4M     <= bus.PC_4E;
      bus.ext_immM  <= bus.ext_immE;
      bus.A_rtM     <= bus.A_rtE;
      bus.AwriteM   <= bus.AwriteE;
      bus.TnewM     <= bus.TnewE == '0 ? '0 : bus.TnewE - TNEW_W'(1);
    end
  // ResultW replaces the stale register-file value when W produces rt
  assign sd = bus.forwardM ? bus.ResultW : write_data_m;
  dm #(.WORDS(DM_WORDS)) u_dm (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (mem_write_m),
    .op     (mem_op_m),
    .addr   (bus.ALUoutM),
    .wd     (sd),
    .pc_4   (bus.PC_4M),
    .rd     (bus.ReadDataM)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model
module tb_mem_stage;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  mem_stage_if bus();
  mem_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;
  logic [31:0] mm [1024];
  logic        m_rw, m_we;
  logic [1:0]  m_mtr, m_tnew;
  logic [2:0]  m_op;
  logic [31:0] m_alu, m_wd, m_pc4, m_imm;
  logic [4:0]  m_art, m_aw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_load();
    logic [31:0] v = mm[m_alu[11:2]];
    int b = int'(m_alu[1:0]) * 8;
    int h = int'(m_alu[1]) * 16;
    case (m_op)
      3'd1: return {16'd0, v[h +: 16]};
      3'd2: return {{16{v[h+15]}}, v[h +: 16]};
      3'd3: return {24'd0, v[b +: 8]};
      3'd4: return {{24{v[b+7]}}, v[b +: 8]};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] model_store_word();
    logic [31:0] v = mm[m_alu[11:2]];
    logic [31:0] sd = bus.forwardM ? bus.ResultW : m_wd;
    case (m_op)
      3'd1, 3'd2: v[int'(m_alu[1]) * 16 +: 16] = sd[15:0];
      3'd3, 3'd4: v[int'(m_alu[1:0]) * 8 +: 8] = sd[7:0];
      default: v = sd;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) mm[i] <= '0;
      {m_rw, m_we, m_mtr, m_tnew, m_op, m_alu, m_wd, m_pc4, m_imm, m_art, m_aw} <= '0;
    end else begin
      if (m_we) mm[m_alu[11:2]] <= model_store_word();
      m_rw   <= bus.RegWriteE;
      m_we   <= bus.MemWriteE;
      m_mtr  <= bus.MemtoRegE;
      m_op   <= bus.MemOpE;
      m_alu  <= bus.ALUoutE;
      m_wd   <= bus.WriteDataE;
      m_pc4  <= bus.PC_4E;
      m_imm  <= bus.ext_immE;
      m_art  <= bus.A_rtE;
      m_aw   <= bus.AwriteE;
      m_tnew <= bus.TnewE == 2'd0 ? 2'd0 : bus.TnewE - 2'd1;
    end

  always @(posedge clk)
    if (chk_en) begin
      #2;
      check("RegWriteM", 32'(bus.RegWriteM), 32'(m_rw));
      check("MemtoRegM", 32'(bus.MemtoRegM), 32'(m_mtr));
      check("PC_4M", bus.PC_4M, m_pc4);
      check("ext_immM", bus.ext_immM, m_imm);
      check("A_rtM", 32'(bus.A_rtM), 32'(m_art));
      check("AwriteM", 32'(bus.AwriteM), 32'(m_aw));
      check("ALUoutM", bus.ALUoutM, m_alu);
      check("TnewM", 32'(bus.TnewM), 32'(m_tnew));
      check("ReadDataM", bus.ReadDataM, model_load());
    end

  task automatic step(input logic we, input logic [2:0] op, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [1:0] tnew, input logic fwd, input logic [31:0] resw);
    bus.RegWriteE  = 1'($urandom);
    bus.MemWriteE  = we;
    bus.MemtoRegE  = 2'($urandom);
    bus.MemOpE     = op;
    bus.ALUoutE    = alu;
    bus.WriteDataE = wd;
    bus.PC_4E      = $urandom;
    bus.ext_immE   = $urandom;
    bus.TnewE      = tnew;
    bus.A_rtE      = 5'($urandom);
    bus.AwriteE    = 5'($urandom);
    bus.forwardM   = fwd;
    bus.ResultW    = resw;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_ALUoutM", bus.ALUoutM, 32'd0);
    check("rst_RegWriteM", 32'(bus.RegWriteM), 32'd0);
    check("rst_TnewM", 32'(bus.TnewM), 32'd0);
    check("rst_PC_4M", bus.PC_4M, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic ld(input logic [2:0] op, input logic [31:0] a, input string name, input logic [31:0] exp);
    step(1'b0, op, a, $urandom, 2'd0, 1'b0, $urandom);
    check(name, bus.ReadDataM, exp);
  endtask

  initial begin
    {bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE, bus.MemOpE, bus.ALUoutE, bus.WriteDataE, bus.PC_4E,
     bus.ext_immE, bus.TnewE, bus.A_rtE, bus.AwriteE, bus.forwardM, bus.ResultW} = '0;
    #1;
    do_reset();
    chk_en = 1'b1;
    check("rel_ReadDataM", bus.ReadDataM, 32'd0);
    ld(MEMOP_W, 32'h0, "lw_0_after_reset", 32'h0);
    step(1'b1, MEMOP_W, 32'h10, 32'h12345678, 2'd0, 1'b0, 32'h0);
    ld(MEMOP_W, 32'h10, "lw_after_sw", 32'h12345678);
    step(1'b1, MEMOP_B, 32'h13, 32'h000000AB, 2'd0, 1'b0, 32'h0);
    ld(MEMOP_W, 32'h10, "lw_after_sb", 32'hAB345678);
    ld(MEMOP_B, 32'h13, "lb_0x13", 32'hFFFFFFAB);
    ld(MEMOP_BU, 32'h13, "lbu_0x13", 32'h000000AB);
    step(1'b1, MEMOP_H, 32'h12, 32'h00008001, 2'd0, 1'b0, 32'h0);
    ld(MEMOP_W, 32'h10, "lw_after_sh", 32'h80015678);
    ld(MEMOP_H, 32'h12, "lh_0x12", 32'hFFFF8001);
    ld(MEMOP_HU, 32'h10, "lhu_0x10", 32'h00005678);
    ld(3'b111, 32'h13, "op7_is_word", 32'h80015678);
    step(1'b1, MEMOP_W, 32'h20, 32'h0, 2'd0, 1'b0, 32'h0);
    step(1'b0, MEMOP_W, 32'h20, 32'h0, 2'd0, 1'b1, 32'hCAFEF00D);
    check("fwd_store", bus.ReadDataM, 32'hCAFEF00D);
    step(1'b0, MEMOP_W, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0);
    check("tnew_2", 32'(bus.TnewM), 32'd1);
    step(1'b0, MEMOP_W, 32'h0, 32'h0, 2'd1, 1'b0, 32'h0);
    check("tnew_1", 32'(bus.TnewM), 32'd0);
    step(1'b0, MEMOP_W, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    check("tnew_0", 32'(bus.TnewM), 32'd0);
    ld(MEMOP_W, 32'h1010, "alias_0x1010", 32'h80015678);
    step(1'b1, MEMOP_W, 32'hFFFF_F014, 32'h0BADBEEF, 2'd0, 1'b0, 32'h0);
    ld(MEMOP_W, 32'h14, "alias_store", 32'h0BADBEEF);
    step(1'b1, MEMOP_W, 32'h30, 32'h5555AAAA, 2'd0, 1'b0, 32'h0);
    do_reset();
    ld(MEMOP_W, 32'h30, "store_lost_in_reset", 32'h0);
    ld(MEMOP_W, 32'h10, "dm_cleared", 32'h0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 63)),
                $urandom, 2'($urandom), $urandom_range(0, 3) == 0, $urandom);
    end
    chk_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
